systolic_output_deskew: RTL
===========================

# systolic_output_deskew

Downstream companion of the systolic row array. It captures the per-row partial-sum results, which leave the array staggered by one cycle per row, and realigns them so that all rows belonging to one input vector form a single output word. It buffers aligned words in a small FIFO and hands them to the consumer over a valid/ready handshake. The array itself cannot stall, so a full FIFO drops the word and sets a sticky overflow flag.

## Interface
- PARTIAL_SUM_BW, 19, width of one row result (signed)
- NUM_PE_ROWS, 8, number of PE rows / results per vector (≥2)
- FIFO_DEPTH, 4, aligned-word entries (power of two, ≥2)
- IDX_BW, 8, width of vector sequence index

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of pipeline, FIFO, index, overflow
- res_valid  in  1  row 0 result for a new vector is valid this cycle
- result  in  NUM_PE_ROWS*PARTIAL_SUM_BW  row i at [(i+1)*PARTIAL_SUM_BW-1 -: PARTIAL_SUM_BW], signed
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  NUM_PE_ROWS*PARTIAL_SUM_BW  aligned word, same row packing as result
- out_idx  out  IDX_BW  sequence index of head word
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky: an aligned word was dropped

## Operation
- Stagger contract: if res_valid is high in cycle t, row i's result for that vector is on `result` in cycle t+i. There are no holes: every row's data is present in its cycle.
- Align stage: row i passes through D_i = NUM_PE_ROWS-1-i registers. Row NUM_PE_ROWS-1 is used combinationally. res_valid passes through a NUM_PE_ROWS-1-stage shift register, producing align_valid.
- The aligned word is complete in cycle t+NUM_PE_ROWS-1.
- Back-to-back vectors (res_valid on consecutive cycles) are fully supported. The pipeline has no occupancy limit.
- Push: align_valid && (not full || pop). Pop: out_valid && out_ready.
- Push when full with no pop: the word is dropped, overflow is set to 1, and the index does not advance.
- Full with simultaneous push and pop: both occur, count is unchanged, no drop.
- The index counter increments on every successful push and is stored with the entry. It wraps from 2^IDX_BW-1 to 0.
- FIFO: circular buffer with read/write pointers and count. out_data and out_idx come straight from the head entry, with no extra register. They are stable while out_valid && !out_ready.
- Values are passed bit-exact: no sign extension, saturation or reordering.
- clr (synchronous, has priority over push and pop in the same cycle):
  - clears the valid shift register, FIFO pointers and count, index, and overflow;
  - data registers are left unchanged;
  - a res_valid in the clr cycle is discarded.
- Reset (rstn low, asynchronous): the same state as clr is cleared. A vector in flight is lost.

## Timing
- Reset values: out_valid 0, out_data 0, out_idx 0, fifo_count 0, overflow 0.
- Latency from res_valid in cycle t (empty FIFO): out_valid rises in cycle t+NUM_PE_ROWS (t+8 by default).
- fifo_count updates on the edge after a push or pop.
- overflow rises on the edge after the drop cycle. It clears only on clr or reset.
- Throughput: one word per cycle in and out when out_ready is held high.

## Test plan
- Single vector, NUM_PE_ROWS=8:
  - Stimulus: res_valid in cycle 10; row i value = 100·(i+1) in cycle 10+i; row 7 = −5 in cycle 17; out_ready=1.
  - Required response: out_valid only in cycle 18, rows = 100,200,…,700,−5, out_idx=0.
- Back-to-back streaming:
  - Stimulus: 20 vectors on consecutive cycles, row i of vector k = k·16+i, out_ready=1.
  - Required response: 20 consecutive out_valid words in order, out_idx 0..19, overflow stays 0.
- Backpressure and overflow (FIFO_DEPTH=4):
  - Stimulus: out_ready=0, 6 vectors.
  - Required response: fifo_count reaches 4. Vectors 4 and 5 are dropped, overflow=1. Releasing out_ready yields idx 0–3 only, unchanged data. The next vector gets idx 4.
- Full with simultaneous push and pop:
  - Stimulus: FIFO at 4; pulse out_ready for one cycle exactly when the next aligned word arrives.
  - Required response: fifo_count stays 4, no overflow, head advances.
- Index wrap:
  - Stimulus: 260 vectors with out_ready=1.
  - Required response: out_idx goes 255 → 0 → 3.
- clr and reset mid-flight:
  - Stimulus: assert clr in cycle t+3 of an in-flight vector with 2 entries stored.
  - Required response: fifo_count=0, out_valid=0, overflow=0, no word is emitted for the in-flight vector. Repeat with rstn low mid-cycle: outputs drop to reset values immediately.

Source files
------------

// File: rtl/systolic_output_deskew_if.sv
// Bus bundle for systolic_output_deskew: staggered row results in,
// aligned and indexed words out, plus FIFO status.
//
// Handshake: res_valid is a one-cycle marker with no back-pressure. The
// array cannot stall, so there is no ready on that side. On the output
// side a word transfers in every cycle where out_valid && out_ready are
// both high. While out_valid is high and out_ready is low, out_valid,
// out_data and out_idx hold steady. out_valid never depends on out_ready.
interface systolic_output_deskew_if #(
  parameter int PARTIAL_SUM_BW = 19,
  parameter int NUM_PE_ROWS    = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int IDX_BW         = 8
);
  localparam int DW     = NUM_PE_ROWS * PARTIAL_SUM_BW;
  localparam int CNT_BW = $clog2(FIFO_DEPTH) + 1;

  logic              res_valid;
  logic [DW-1:0]     result;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [IDX_BW-1:0] out_idx;
  logic [CNT_BW-1:0] fifo_count;
  logic              overflow;

  // Producer/consumer side: the array driver and the word consumer.
  modport master (
    output res_valid, result, out_ready,
    input  out_valid, out_data, out_idx, fifo_count, overflow
  );

  // Deskew block side.
  modport slave (
    input  res_valid, result, out_ready,
    output out_valid, out_data, out_idx, fifo_count, overflow
  );
endinterface

// File: rtl/systolic_output_deskew.sv
// Realigns the one-cycle-per-row staggered results of the systolic row
// array into one word per input vector. Aligned words are tagged with a
// sequence index and buffered in a small circular FIFO. The array cannot
// stall, so a word that arrives while the FIFO is full and not popping is
// dropped, and a sticky overflow flag records the loss.
module systolic_output_deskew #(
  parameter int PARTIAL_SUM_BW = 19,
  parameter int NUM_PE_ROWS    = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int IDX_BW         = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  systolic_output_deskew_if.slave io
);

  localparam int DW     = NUM_PE_ROWS * PARTIAL_SUM_BW;
  localparam int PTR_BW = $clog2(FIFO_DEPTH);
  localparam int CNT_BW = PTR_BW + 1;
  localparam int ENT_BW = IDX_BW + DW;
  localparam int VLD_BW = NUM_PE_ROWS - 1;
  localparam logic [CNT_BW-1:0] DEPTH_CNT = CNT_BW'(FIFO_DEPTH);

  // ------------------------------------------------------------------
  // Align stage
  // ------------------------------------------------------------------
  logic [PARTIAL_SUM_BW-1:0] in_row      [NUM_PE_ROWS];
  logic [PARTIAL_SUM_BW-1:0] aligned_row [NUM_PE_ROWS];
  logic [DW-1:0]             aligned_word;
  logic                      align_valid;

  // Split the packed input bus into per-row slices.
  always_comb begin
    for (int i = 0; i < NUM_PE_ROWS; i++) begin
      in_row[i] = io.result[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
    end
  end

  // Row i arrives i cycles after row 0. It is delayed by the remaining
  // NUM_PE_ROWS-1-i cycles so that all rows line up with the last row,
  // which is used straight from the input. These are pure data flops.
  // They are neither reset nor cleared, because the valid pipe alone
  // decides whether their contents are used.
  for (genvar g = 0; g < NUM_PE_ROWS; g++) begin : g_row
    if (g == NUM_PE_ROWS - 1) begin : g_last
      assign aligned_row[g] = in_row[g];
    end else begin : g_dly
      localparam int D = NUM_PE_ROWS - 1 - g;
      logic [PARTIAL_SUM_BW-1:0] dly_q [D];
      logic [PARTIAL_SUM_BW-1:0] dly_d [D];

      // Shift this row one stage per cycle.
      always_comb begin
        dly_d[0] = in_row[g];
        for (int k = 1; k < D; k++) begin
          dly_d[k] = dly_q[k-1];
        end
      end

      // Delay-line storage for this row.
      always_ff @(posedge clk) begin
        dly_q <= dly_d;
      end

      assign aligned_row[g] = dly_q[D-1];
    end
  end

  // Pack the aligned rows back into the bus layout, bit-exact.
  always_comb begin
    aligned_word = '0;
    for (int i = 0; i < NUM_PE_ROWS; i++) begin
      aligned_word[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = aligned_row[i];
    end
  end

  logic [VLD_BW-1:0] vld_q;
  logic [VLD_BW-1:0] vld_d;

  // Carry the row-0 valid marker alongside the slowest data path. A marker
  // seen during clr is discarded together with everything already in flight.
  always_comb begin
    vld_d[0] = io.res_valid;
    for (int k = 1; k < VLD_BW; k++) begin
      vld_d[k] = vld_q[k-1];
    end
    if (clr) begin
      vld_d = '0;
    end
  end

  // Valid shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign align_valid = vld_q[VLD_BW-1];

  // ------------------------------------------------------------------
  // Output FIFO
  // ------------------------------------------------------------------
  logic [ENT_BW-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_BW-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_BW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BW-1:0] count_q, count_d;
  logic [IDX_BW-1:0] idx_q, idx_d;
  logic              ovf_q, ovf_d;

  logic fifo_full;
  logic fifo_nonempty;
  logic do_pop;
  logic do_push;
  logic do_drop;

  // Push/pop decisions. A pop frees the slot the push needs in the same
  // cycle, so a full FIFO still accepts when the head is taken. clr
  // overrides both.
  always_comb begin
    fifo_full     = (count_q == DEPTH_CNT);
    fifo_nonempty = (count_q != '0);
    do_pop        = fifo_nonempty && io.out_ready && !clr;
    do_push       = align_valid && (!fifo_full || do_pop) && !clr;
    do_drop       = align_valid && fifo_full && !do_pop && !clr;
  end

  // Next-state for pointers, occupancy, sequence index and overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q | do_drop;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      idx_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_BW'(1);
        idx_d    = idx_q + IDX_BW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_BW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_BW'(1);
        2'b01:   count_d = count_q - CNT_BW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state of the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
    end
  end

  // Write the aligned word and its index into the tail slot.
  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = {idx_q, aligned_word};
    end
  end

  // Entry storage. It holds data only, so it is neither reset nor cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The head entry drives the outputs directly. It is masked to zero when
  // the FIFO is empty, so stale storage never shows on the bus.
  always_comb begin
    io.out_valid  = fifo_nonempty;
    io.out_data   = '0;
    io.out_idx    = '0;
    if (fifo_nonempty) begin
      io.out_data = mem_q[rd_ptr_q][DW-1:0];
      io.out_idx  = mem_q[rd_ptr_q][ENT_BW-1:DW];
    end
    io.fifo_count = count_q;
    io.overflow   = ovf_q;
  end

endmodule
